// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel produces a 50% duty square wave whose half-period (in clk_in
// cycles) is programmable at run time. New half-periods are held in a shadow
// register and only take effect at the end of a full period (high->low edge),
// or right away while the channel is idle, so the outputs never glitch.
module clk_div_multi #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned CNT_W    = 25,
  parameter int unsigned DEF_HALF = 1000000
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_tick,
  output logic [NUM_CH-1:0] cfg_pend
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  // A zero half-period is meaningless; treat it as the fastest legal setting.
  localparam logic [CNT_W-1:0] DEF_V = (DEF_HALF == 0) ? ONE : CNT_W'(DEF_HALF);

  logic [CNT_W-1:0]  act_q [NUM_CH];
  logic [CNT_W-1:0]  act_d [NUM_CH];
  logic [CNT_W-1:0]  shd_q [NUM_CH];
  logic [CNT_W-1:0]  shd_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  state_e            st_q  [NUM_CH];
  state_e            st_d  [NUM_CH];
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  wr_val;

  assign wr_val = (cfg_half == '0) ? ONE : cfg_half;

  // Per-channel next-state: idle/run sequencing, counter, toggle and shadow apply.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      act_d[i]  = act_q[i];
      shd_d[i]  = shd_q[i];
      cnt_d[i]  = cnt_q[i];
      st_d[i]   = st_q[i];
      out_d[i]  = out_q[i];
      tick_d[i] = 1'b0;
      pend_d[i] = pend_q[i];

      case (st_q[i])
        ST_IDLE: begin
          out_d[i] = 1'b0;
          // No period in progress, so a pending value can be applied at once.
          if (pend_q[i]) begin
            act_d[i]  = shd_q[i];
            pend_d[i] = 1'b0;
            cnt_d[i]  = shd_q[i] - ONE;
          end else begin
            cnt_d[i] = act_q[i] - ONE;
          end
          if (ch_en[i]) begin
            st_d[i] = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!out_q[i] && !ch_en[i]) begin
            // Disabled while low: stop immediately, output is already 0.
            st_d[i]  = ST_IDLE;
            cnt_d[i] = act_q[i] - ONE;
          end else if (cnt_q[i] == '0) begin
            out_d[i] = ~out_q[i];
            if (!out_q[i]) begin
              tick_d[i] = 1'b1;
              cnt_d[i]  = act_q[i] - ONE;
            end else begin
              // High->low edge is the period boundary.
              if (pend_q[i]) begin
                act_d[i]  = shd_q[i];
                pend_d[i] = 1'b0;
                cnt_d[i]  = shd_q[i] - ONE;
              end else begin
                cnt_d[i] = act_q[i] - ONE;
              end
              if (!ch_en[i]) begin
                st_d[i] = ST_IDLE;
              end
            end
          end else begin
            cnt_d[i] = cnt_q[i] - ONE;
          end
        end
        default: st_d[i] = ST_IDLE;
      endcase

      // Placed after the apply so a same-cycle write survives it and stays pending.
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        shd_d[i]  = wr_val;
        pend_d[i] = 1'b1;
      end
    end
  end

  // State registers; async reset restores defaults and drops pending writes.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        act_q[i] <= DEF_V;
        shd_q[i] <= DEF_V;
        cnt_q[i] <= DEF_V - ONE;
        st_q[i]  <= ST_IDLE;
      end
      out_q  <= '0;
      tick_q <= '0;
      pend_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        act_q[i] <= act_d[i];
        shd_q[i] <= shd_d[i];
        cnt_q[i] <= cnt_d[i];
        st_q[i]  <= st_d[i];
      end
      out_q  <= out_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign clk_out   = out_q;
  assign rise_tick = tick_q;
  assign cfg_pend  = pend_q;

endmodule
